// File: rtl/ccip_mmio_csr_responder_if.sv
// CCI-P MMIO request/response bundle between the port (master) and the AFU CSR responder (slave).
interface ccip_mmio_csr_responder_if;
  logic         C0RxMMIOWrValid;
  logic         C0RxMMIORdValid;
  logic [15:0]  C0RxMMIOIndex;
  logic [1:0]   C0RxMMIOLen;
  logic [8:0]   C0RxMMIOTid;
  logic [511:0] C0RxData;
  logic         C2TxMMIORdValid;
  logic [8:0]   C2TxTid;
  logic [63:0]  C2TxData;

  modport master (
    output C0RxMMIOWrValid, C0RxMMIORdValid, C0RxMMIOIndex, C0RxMMIOLen, C0RxMMIOTid, C0RxData,
    input  C2TxMMIORdValid, C2TxTid, C2TxData
  );

  modport slave (
    input  C0RxMMIOWrValid, C0RxMMIORdValid, C0RxMMIOIndex, C0RxMMIOLen, C0RxMMIOTid, C0RxData,
    output C2TxMMIORdValid, C2TxTid, C2TxData
  );
endinterface

// File: rtl/ccip_mmio_csr_responder.sv
// CCI-P MMIO CSR responder: NUM_CSR 64-bit CSRs, fixed-latency read completions on C2 Tx.
// Define CCIP_MMIO_DFH_EN to make CSR0 a read-only DFH returning DFH_VALUE.
module ccip_mmio_csr_responder #(
  parameter int          NUM_CSR      = 16,
  parameter logic [15:0] CSR_BASE_IDX = 16'h0000,
  parameter int          RD_LATENCY   = 2,
  parameter logic [63:0] DFH_VALUE    = 64'h0
) (
  input  logic                     clk,
  input  logic                     SoftReset,
  ccip_mmio_csr_responder_if.slave bus,
  output logic [NUM_CSR*64-1:0]    csr_q,
  output logic [NUM_CSR-1:0]       csr_wr_pulse,
  output logic                     err_req,
  output logic [31:0]              rd_count
);

  localparam int IDX_W = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;

  typedef struct packed {
    logic        valid;
    logic [8:0]  tid;
    logic [63:0] data;
  } rdStage_t;

  logic [63:0] csrReg  [NUM_CSR];
  logic [63:0] csrView [NUM_CSR];
  rdStage_t    rdPipe  [RD_LATENCY];

  logic [15:0]      off;
  logic             hit;
  logic             hi;
  logic [IDX_W-1:0] csrIdx;
  logic             fmtBad;
  logic             collide;
  logic             wrEn;
  logic             wrErr;
  logic             rdAcc;
  logic             rdErr;
  logic [63:0]      rdSel;
  logic [63:0]      rdData;

  // Only the low quadword of the write payload is meaningful.
  logic unusedDataBits;
  assign unusedDataBits = ^bus.C0RxData[511:64];

  // Register view seen by SW and by csr_q; CSR0 may be replaced by the DFH constant.
  always_comb begin
    for (int i = 0; i < NUM_CSR; i++) csrView[i] = csrReg[i];
`ifdef CCIP_MMIO_DFH_EN
    csrView[0] = DFH_VALUE;
`endif
  end

  for (genvar g = 0; g < NUM_CSR; g++) begin : gCsrQ
    assign csr_q[g*64 +: 64] = csrView[g];
  end

  // Request decode
  always_comb begin
    off     = bus.C0RxMMIOIndex - CSR_BASE_IDX;
    hit     = (bus.C0RxMMIOIndex >= CSR_BASE_IDX) && (off[15:1] < 15'(NUM_CSR));
    hi      = off[0];
    csrIdx  = off[IDX_W:1];
    fmtBad  = bus.C0RxMMIOLen[1] || (bus.C0RxMMIOLen == 2'b01 && hi);
    collide = bus.C0RxMMIOWrValid && bus.C0RxMMIORdValid;

    wrEn  = bus.C0RxMMIOWrValid && !bus.C0RxMMIORdValid && hit && !fmtBad;
`ifdef CCIP_MMIO_DFH_EN
    if (csrIdx == '0) wrEn = 1'b0;
`endif
    wrErr = bus.C0RxMMIOWrValid && !bus.C0RxMMIORdValid && hit && fmtBad;
    rdAcc = bus.C0RxMMIORdValid && !bus.C0RxMMIOWrValid;
    rdErr = rdAcc && hit && fmtBad;
  end

  // Read data mux; misses and malformed requests complete with zero data.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rdSel = '0;
    for (int i = 0; i < NUM_CSR; i++) begin
      if (csrIdx == IDX_W'(i)) rdSel = csrView[i];
    end
    rdData = '0;
    if (hit && !fmtBad) begin
      if (bus.C0RxMMIOLen == 2'b01) rdData = rdSel;
      else                          rdData = {32'h0, hi ? rdSel[63:32] : rdSel[31:0]};
    end
  end

  // CSR storage and write strobes.
  // NOTE: the CSRs are discrete flops, not a RAM, so the whole array is cleared on reset.
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      for (int i = 0; i < NUM_CSR; i++) csrReg[i] <= '0;
      csr_wr_pulse <= '0;
    end else begin
      csr_wr_pulse <= '0;
      if (wrEn) begin
        csr_wr_pulse <= NUM_CSR'(1) << csrIdx;
        for (int i = 0; i < NUM_CSR; i++) begin
          if (csrIdx == IDX_W'(i)) begin
            if (bus.C0RxMMIOLen == 2'b01) csrReg[i]         <= bus.C0RxData[63:0];
            else if (hi)                  csrReg[i][63:32] <= bus.C0RxData[31:0];
            else                          csrReg[i][31:0]  <= bus.C0RxData[31:0];
          end
        end
      end
    end
  end

  // Error pulse and saturating accepted-read counter
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      err_req  <= 1'b0;
      rd_count <= '0;
    end else begin
      err_req <= collide || wrErr || rdErr;
      if (rdAcc && rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
    end
  end

  // Read completion shift pipe; payload only advances behind a valid so the
  // C2 tid/data hold their last value between responses.
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      for (int i = 0; i < RD_LATENCY; i++) rdPipe[i] <= '0;
    end else begin
      rdPipe[0].valid <= rdAcc;
      if (rdAcc) begin
        rdPipe[0].tid  <= bus.C0RxMMIOTid;
        rdPipe[0].data <= rdData;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        rdPipe[i].valid <= rdPipe[i-1].valid;
        if (rdPipe[i-1].valid) begin
          rdPipe[i].tid  <= rdPipe[i-1].tid;
          rdPipe[i].data <= rdPipe[i-1].data;
        end
      end
    end
  end

  assign bus.C2TxMMIORdValid = rdPipe[RD_LATENCY-1].valid;
  assign bus.C2TxTid         = rdPipe[RD_LATENCY-1].tid;
  assign bus.C2TxData        = rdPipe[RD_LATENCY-1].data;

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// Directed bench for ccip_mmio_csr_responder (NUM_CSR=16, BASE=0, RD_LATENCY=2); DFH checks follow CCIP_MMIO_DFH_EN.
module tb_ccip_mmio_csr_responder;
  localparam int          NUM_CSR = 16;
  localparam int          RD_LAT  = 2;
  localparam logic [63:0] DFH_VAL = 64'h1000_0000_0000_0001;

  logic clk = 1'b0;
  logic SoftReset;
  logic [NUM_CSR*64-1:0] csr_q;
  logic [NUM_CSR-1:0]    csr_wr_pulse;
  logic                  err_req;
  logic [31:0]           rd_count;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [63:0] expCsr0;
  logic [63:0] rstCsr0;
  logic [63:0] expPulse0;

  always #5 clk = ~clk;

  ccip_mmio_csr_responder_if bus ();

  ccip_mmio_csr_responder #(
    .NUM_CSR     (NUM_CSR),
    .CSR_BASE_IDX(16'h0000),
    .RD_LATENCY  (RD_LAT),
    .DFH_VALUE   (DFH_VAL)
  ) dut (
    .clk         (clk),
    .SoftReset   (SoftReset),
    .bus         (bus),
    .csr_q       (csr_q),
    .csr_wr_pulse(csr_wr_pulse),
    .err_req     (err_req),
    .rd_count    (rd_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [15:0] idx,
                       input logic [1:0] len, input logic [8:0] tid, input logic [63:0] d);
    bus.C0RxMMIOWrValid = wr;
    bus.C0RxMMIORdValid = rd;
    bus.C0RxMMIOIndex   = idx;
    bus.C0RxMMIOLen     = len;
    bus.C0RxMMIOTid     = tid;
    bus.C0RxData        = {{448{1'b1}}, d};
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 2'b00, 9'h0, 64'h0);
  endtask

  task automatic expectRsp(input string tag, input logic [8:0] tid, input logic [63:0] data);
    check({tag, "_valid"}, 64'(bus.C2TxMMIORdValid), 64'd1);
    check({tag, "_tid"},   64'(bus.C2TxTid),         64'(tid));
    check({tag, "_data"},  bus.C2TxData,             data);
  endtask

  // Single read from an idle pipe: err pulse after the request edge, response RD_LAT cycles on.
  task automatic readCheck(input string tag, input logic [15:0] idx, input logic [1:0] len,
                           input logic [8:0] tid, input logic [63:0] data, input logic expErr);
    drive(1'b0, 1'b1, idx, len, tid, 64'h0);
    step();
    check({tag, "_err"}, 64'(err_req), 64'(expErr));
    idle();
    for (int i = 0; i < RD_LAT - 1; i++) begin
      check({tag, "_early"}, 64'(bus.C2TxMMIORdValid), 64'd0);
      step();
    end
    expectRsp(tag, tid, data);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef CCIP_MMIO_DFH_EN
    expCsr0   = DFH_VAL;
    rstCsr0   = DFH_VAL;
    expPulse0 = 64'd0;
`else
    expCsr0   = 64'hFFFF_FFFF_FFFF_FFFF;
    rstCsr0   = 64'd0;
    expPulse0 = 64'd1;
`endif
    idle();
    SoftReset = 1'b1;
    step();
    step();
    check("rst_valid",   64'(bus.C2TxMMIORdValid), 64'd0);
    check("rst_rdcount", 64'(rd_count),            64'd0);
    check("rst_err",     64'(err_req),             64'd0);
    check("rst_pulse",   64'(csr_wr_pulse),        64'd0);
    check("rst_csr_hi",  64'(|csr_q[NUM_CSR*64-1:64]), 64'd0);
    check("rst_csr0",    csr_q[63:0],              rstCsr0);
    SoftReset = 1'b0;
    step();

    // 1: 8B write CSR2, read-after-write next cycle
    drive(1'b1, 1'b0, 16'd4, 2'b01, 9'h0, 64'hDEAD_BEEF_0123_4567);
    step();
    check("t1_pulse", 64'(csr_wr_pulse), 64'h0004);
    check("t1_csr2",  csr_q[2*64 +: 64], 64'hDEAD_BEEF_0123_4567);
    check("t1_werr",  64'(err_req), 64'd0);
    readCheck("t1_rd", 16'd4, 2'b01, 9'h05, 64'hDEAD_BEEF_0123_4567, 1'b0);
    step();
    check("t1_idle_valid", 64'(bus.C2TxMMIORdValid), 64'd0);
    check("t1_hold_tid",   64'(bus.C2TxTid), 64'h05);
    check("t1_hold_data",  bus.C2TxData, 64'hDEAD_BEEF_0123_4567);
    check("t1_pulse_off",  64'(csr_wr_pulse), 64'h0);

    // 2: 4B write to upper half of CSR2 (payload bits above 31 are junk)
    drive(1'b1, 1'b0, 16'd5, 2'b00, 9'h0, 64'hFFFF_FFFF_CAFE_F00D);
    step();
    check("t2_pulse", 64'(csr_wr_pulse), 64'h0004);
    check("t2_csr2",  csr_q[2*64 +: 64], 64'hCAFE_F00D_0123_4567);
    readCheck("t2_rd4hi", 16'd5, 2'b00, 9'h06, 64'h0000_0000_CAFE_F00D, 1'b0);
    readCheck("t2_rd8",   16'd4, 2'b01, 9'h07, 64'hCAFE_F00D_0123_4567, 1'b0);
    readCheck("t2_rd4lo", 16'd4, 2'b00, 9'h08, 64'h0000_0000_0123_4567, 1'b0);
    check("t2_rdcount", 64'(rd_count), 64'd4);

    // 3: back-to-back reads keep order
    drive(1'b0, 1'b1, 16'd4, 2'b01, 9'h1, 64'h0);
    step();
    drive(1'b0, 1'b1, 16'd4, 2'b01, 9'h2, 64'h0);
    step();
    expectRsp("t3_r1", 9'h1, 64'hCAFE_F00D_0123_4567);
    drive(1'b0, 1'b1, 16'd5, 2'b00, 9'h3, 64'h0);
    step();
    expectRsp("t3_r2", 9'h2, 64'hCAFE_F00D_0123_4567);
    idle();
    step();
    expectRsp("t3_r3", 9'h3, 64'h0000_0000_CAFE_F00D);
    step();
    check("t3_done", 64'(bus.C2TxMMIORdValid), 64'd0);
    check("t3_rdcount", 64'(rd_count), 64'd7);

    // 4: malformed and missing reads/writes
    readCheck("t4_odd8",  16'd3,  2'b01, 9'h1AA, 64'h0, 1'b1);
    readCheck("t4_miss",  16'd32, 2'b00, 9'h00F, 64'h0, 1'b0);
    readCheck("t4_len10", 16'd5,  2'b10, 9'h010, 64'h0, 1'b1);
    check("t4_rdcount", 64'(rd_count), 64'd10);
    drive(1'b1, 1'b0, 16'd6, 2'b10, 9'h0, 64'h1111_2222_3333_4444);
    step();
    check("t4_wlen_err",   64'(err_req), 64'd1);
    check("t4_wlen_pulse", 64'(csr_wr_pulse), 64'h0);
    drive(1'b1, 1'b0, 16'd40, 2'b01, 9'h0, 64'h5555_6666_7777_8888);
    step();
    check("t4_wmiss_err",   64'(err_req), 64'd0);
    check("t4_wmiss_pulse", 64'(csr_wr_pulse), 64'h0);
    drive(1'b1, 1'b0, 16'd7, 2'b01, 9'h0, 64'h9999_AAAA_BBBB_CCCC);
    step();
    check("t4_wodd_err", 64'(err_req), 64'd1);
    check("t4_csr3",     csr_q[3*64 +: 64], 64'h0);

    // 5: write and read in the same cycle
    drive(1'b1, 1'b1, 16'd4, 2'b01, 9'h033, 64'h0);
    step();
    check("t5_err",   64'(err_req), 64'd1);
    check("t5_pulse", 64'(csr_wr_pulse), 64'h0);
    check("t5_csr2",  csr_q[2*64 +: 64], 64'hCAFE_F00D_0123_4567);
    idle();
    step();
    check("t5_norsp1", 64'(bus.C2TxMMIORdValid), 64'd0);
    step();
    check("t5_norsp2", 64'(bus.C2TxMMIORdValid), 64'd0);
    check("t5_rdcount", 64'(rd_count), 64'd10);

    // CSR0: plain RW by default, read-only DFH when enabled
    drive(1'b1, 1'b0, 16'd0, 2'b01, 9'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("t6_pulse0", 64'(csr_wr_pulse[0]), expPulse0);
    check("t6_csr0",   csr_q[63:0], expCsr0);
    check("t6_err",    64'(err_req), 64'd0);
    readCheck("t6_rd8",   16'd0, 2'b01, 9'h020, expCsr0, 1'b0);
    readCheck("t6_rd4hi", 16'd1, 2'b00, 9'h021, {32'h0, expCsr0[63:32]}, 1'b0);
    check("t6_rdcount", 64'(rd_count), 64'd12);

    // Reset with reads in flight drops them
    drive(1'b0, 1'b1, 16'd4, 2'b01, 9'h044, 64'h0);
    step();
    drive(1'b0, 1'b1, 16'd4, 2'b01, 9'h045, 64'h0);
    #2 SoftReset = 1'b1;
    step();
    idle();
    check("t7_rst_valid",   64'(bus.C2TxMMIORdValid), 64'd0);
    check("t7_rst_csr_hi",  64'(|csr_q[NUM_CSR*64-1:64]), 64'd0);
    check("t7_rst_rdcount", 64'(rd_count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t7_norsp", 64'(bus.C2TxMMIORdValid), 64'd0);
    end
    SoftReset = 1'b0;
    step();
    check("t7_post_valid", 64'(bus.C2TxMMIORdValid), 64'd0);
    readCheck("t7_rd", 16'd4, 2'b01, 9'h046, 64'h0, 1'b0);
    check("t7_rdcount", 64'(rd_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
